// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard controller.
//   - hazard_state_t : controller FSM states (RUN / STALL / FLUSH)
//   - fwd_sel_t      : operand source select (REGFILE / EX / MEM)
//   - tag_entry_t    : per-stage destination tag {valid, rd, reg_write, mem_read}
//   - XZR_IDX        : register index 31, the zero register, never a producer
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        REGFILE = 2'b00,
        EX      = 2'b01,
        MEM     = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } tag_entry_t;

    localparam int TAG_W = $bits(tag_entry_t);

    // An entry only produces a value if it is live, writes a register,
    // and that register is not the zero register.
    function automatic logic is_producer(input tag_entry_t e);
        return e.valid & e.reg_write & (e.rd != XZR_IDX);
    endfunction

    // A source operand hits a stage when the operand is actually read and
    // the stage produces exactly that register.
    function automatic logic src_hit(input tag_entry_t e, input logic [4:0] r,
                                     input logic uses);
        return uses & is_producer(e) & (e.rd == r);
    endfunction

endpackage

// File: rtl/stage_tag_pipe.sv
// -----------------------------------------------------------------------------
// stage_tag_pipe
// Three-deep shadow of the destination tags travelling through EX, MEM and WB.
// Shifts every cycle; the EX slot takes the DEC destination when load_en is
// high, otherwise a bubble.
//
// Ports
//   clk            in   clock, all updates on posedge
//   reset          in   synchronous active-high, empties every slot
//   load_en        in   DEC instruction advances into EX this cycle
//   dec_rd         in   [4:0] destination register of the DEC instruction
//   dec_reg_write  in   DEC instruction writes dec_rd
//   dec_mem_read   in   DEC instruction is a load
//   ex_tag         out  [TAG_W-1:0] packed tag_entry_t for the EX stage
//   mem_tag        out  [TAG_W-1:0] packed tag_entry_t for the MEM stage
//   wb_tag         out  [TAG_W-1:0] packed tag_entry_t for the WB stage
// -----------------------------------------------------------------------------
module stage_tag_pipe
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [4:0]       dec_rd,
    input  logic             dec_reg_write,
    input  logic             dec_mem_read,
    output logic [TAG_W-1:0] ex_tag,
    output logic [TAG_W-1:0] mem_tag,
    output logic [TAG_W-1:0] wb_tag
);

    tag_entry_t ex_d;
    tag_entry_t ex_q;
    tag_entry_t mem_q;
    tag_entry_t wb_q;

    // Build the next EX entry; a bubble is an all-zero entry.
    always_comb begin
        ex_d = '0;
        if (load_en) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = dec_rd;
            ex_d.reg_write = dec_reg_write;
            ex_d.mem_read  = dec_mem_read;
        end
    end

    // Advance every stage by one each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_tag  = ex_q;
    assign mem_tag = mem_q;
    assign wb_tag  = wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Data/control hazard controller for a 5-stage in-order pipeline. Compares the
// DEC source operands against in-flight destination tags, raises stalls,
// selects operand forwarding and flushes IF/DEC on taken branches.
//
// Build option: define HAZARD_FORWARDING_EN to enable EX/MEM forwarding, in
// which case only load-use stalls remain. Without it every EX or MEM match
// stalls until the producer reaches WB and fwd_a/fwd_b stay 00.
//
// Ports
//   clk            in   clock, all updates on posedge
//   reset          in   synchronous active-high; forces all outputs to 0
//   dec_valid      in   DEC holds a real instruction
//   dec_rn/dec_rm  in   [4:0] DEC source registers
//   dec_uses_rn/rm in   DEC actually reads rn / rm
//   dec_rd         in   [4:0] DEC destination register
//   dec_reg_write  in   DEC writes dec_rd
//   dec_mem_read   in   DEC is a load
//   br_taken       in   branch in DEC resolved taken this cycle
//   pc_stall       out  hold PC
//   ifid_stall     out  hold IF/DEC register
//   idex_bubble    out  load NOP into DEC/EX
//   ifid_flush     out  clear IF/DEC register
//   fwd_a/fwd_b    out  [1:0] operand source: 00 regfile, 01 EX, 10 MEM
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic [4:0] dec_rn,
    input  logic [4:0] dec_rm,
    input  logic       dec_uses_rn,
    input  logic       dec_uses_rm,
    input  logic [4:0] dec_rd,
    input  logic       dec_reg_write,
    input  logic       dec_mem_read,
    input  logic       br_taken,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_STALL = STALL;
    localparam logic [1:0] S_FLUSH = FLUSH;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [1:0]       stall_run;
    logic [TAG_W-1:0] ex_bits;
    logic [TAG_W-1:0] mem_bits;
    logic [TAG_W-1:0] wb_bits;
    tag_entry_t       ex_tag;
    tag_entry_t       mem_tag;
    logic             dec_live;
    logic             use_rn;
    logic             use_rm;
    logic             ex_rn_hit;
    logic             ex_rm_hit;
    logic             mem_rn_hit;
    logic             mem_rm_hit;
    logic             hazard_raw;
    logic             hazard;
    logic             flush_req;
    logic             load_ex;
    fwd_sel_t         fwd_a_sel;
    fwd_sel_t         fwd_b_sel;

    assign ex_tag  = tag_entry_t'(ex_bits);
    assign mem_tag = tag_entry_t'(mem_bits);

    // The cycle after a flush, IF/DEC has just been cleared, so whatever sits
    // on the DEC inputs is treated as a bubble.
    assign dec_live = dec_valid & (state != S_FLUSH);
    assign use_rn   = dec_live & dec_uses_rn;
    assign use_rm   = dec_live & dec_uses_rm;

    assign ex_rn_hit  = src_hit(ex_tag,  dec_rn, use_rn);
    assign ex_rm_hit  = src_hit(ex_tag,  dec_rm, use_rm);
    assign mem_rn_hit = src_hit(mem_tag, dec_rn, use_rn);
    assign mem_rm_hit = src_hit(mem_tag, dec_rm, use_rm);

    // WB is never compared: the register file writes before it is read.
`ifdef HAZARD_FORWARDING_EN
    assign hazard_raw = ex_tag.mem_read & (ex_rn_hit | ex_rm_hit);
`else
    assign hazard_raw = ex_rn_hit | ex_rm_hit | mem_rn_hit | mem_rm_hit;
`endif

    // Stall is combinational so the PC and IF/DEC hold in the detection cycle.
    // A pending branch waits behind the stall and is taken once operands are
    // available.
    assign hazard    = hazard_raw & ~reset;
    assign flush_req = dec_live & br_taken & ~hazard & ~reset;
    assign load_ex   = dec_live & ~hazard;

    stage_tag_pipe u_tag_pipe (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_ex),
        .dec_rd        (dec_rd),
        .dec_reg_write (dec_reg_write),
        .dec_mem_read  (dec_mem_read),
        .ex_tag        (ex_bits),
        .mem_tag       (mem_bits),
        .wb_tag        (wb_bits)
    );

    // Youngest producer wins; nothing is forwarded into a bubble.
`ifdef HAZARD_FORWARDING_EN
    always_comb begin
        fwd_a_sel = REGFILE;
        fwd_b_sel = REGFILE;
        if (!reset && !hazard) begin
            if (ex_rn_hit) begin
                fwd_a_sel = EX;
            end else if (mem_rn_hit) begin
                fwd_a_sel = MEM;
            end
            if (ex_rm_hit) begin
                fwd_b_sel = EX;
            end else if (mem_rm_hit) begin
                fwd_b_sel = MEM;
            end
        end
    end
`else
    assign fwd_a_sel = REGFILE;
    assign fwd_b_sel = REGFILE;
`endif

    // A branch resolved on the cycle a stall clears goes straight to FLUSH,
    // so STALL may exit either to RUN or to FLUSH.
    always_comb begin
        state_next = S_RUN;
        case (state)
            S_RUN, S_STALL: begin
                if (hazard) begin
                    state_next = S_STALL;
                end else if (flush_req) begin
                    state_next = S_FLUSH;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_FLUSH: state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    // State register plus a count of consecutive stall cycles already spent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            stall_run <= 2'd0;
        end else begin
            state <= state_next;
            if (hazard) begin
                stall_run <= (stall_run == 2'd3) ? 2'd3 : stall_run + 2'd1;
            end else begin
                stall_run <= 2'd0;
            end
        end
    end

    assign pc_stall    = hazard;
    assign ifid_stall  = hazard;
    assign idex_bubble = hazard;
    assign ifid_flush  = flush_req;
    assign fwd_a       = fwd_a_sel;
    assign fwd_b       = fwd_b_sel;

    // Each stall cycle drains one producer stage, so after two bubbles EX and
    // MEM are empty and a third stall cycle cannot be requested.
    a_stall_bound: assert property (@(posedge clk) hazard |-> (stall_run < 2'd2));

    // FLUSH always lasts a single cycle.
    a_flush_once: assert property (@(posedge clk) (state == S_FLUSH) |=> (state == S_RUN));

    // The tag pipe advances one stage per cycle outside reset.
    a_tag_shift: assert property (@(posedge clk)
        (!reset && !$past(reset)) |->
        ((mem_bits == $past(ex_bits)) && (wb_bits == $past(mem_bits))));

endmodule
